// File: rtl/ahb_apb_bridge_ctrl_p_if.sv
// AHB-side transfer handshake and APB3 bus signals grouped for the bridge controller.
interface ahb_apb_bridge_ctrl_p_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SLV = 4
);
    // AHB side
    logic               valid;
    logic               hwrite;
    logic [ADDR_W-1:0]  haddr;
    logic [DATA_W-1:0]  hwdata;
    logic [DATA_W-1:0]  hrdata;
    logic               hreadyout;
    logic [1:0]         hresp;
    // APB side
    logic [ADDR_W-1:0]  paddr;
    logic [DATA_W-1:0]  pwdata;
    logic               pwrite;
    logic [NUM_SLV-1:0] psel;
    logic               penable;
    logic [DATA_W-1:0]  prdata;
    logic               pready;
    logic               pslverr;

    // Bridge view
    modport slave (
        input  valid, hwrite, haddr, hwdata, prdata, pready, pslverr,
        output hrdata, hreadyout, hresp, paddr, pwdata, pwrite, psel, penable
    );

    // AHB front end / APB slaves view
    modport master (
        output valid, hwrite, haddr, hwdata, prdata, pready, pslverr,
        input  hrdata, hreadyout, hresp, paddr, pwdata, pwrite, psel, penable
    );
endinterface

// File: rtl/ahb_apb_bridge_ctrl_p.sv
// AHB-to-APB3 bridge controller: one APB access per AHB transfer, one-hot slave select
// decoded from haddr, two-cycle AHB ERROR on decode error, slave error or pready timeout.
module ahb_apb_bridge_ctrl_p #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned SLV_LSB = 12,
    parameter int unsigned TIMEOUT = 16
) (
    input logic                    i_hclk,
    input logic                    i_hresetn,
    ahb_apb_bridge_ctrl_p_if.slave bus
);
    localparam int unsigned SlvW     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned CntW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CntLastI = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [2:0] {
        StIdle, StWdata, StSetup, StAccess, StDone, StErr1, StErr2
    } state_e;

    state_e              r_state, w_state_d;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [DATA_W-1:0]   r_hrdata;
    logic                r_pwrite;
    logic [SlvW-1:0]     r_idx, w_idx_d;
    logic [CntW-1:0]     r_cnt, w_cnt_d;
    logic                r_hreadyout, w_hreadyout_d;
    logic [1:0]          r_hresp, w_hresp_d;
    logic [NUM_SLV-1:0]  r_psel, w_psel_d;
    logic                r_penable, w_penable_d;

    logic                w_accept;
    logic [SlvW-1:0]     w_haddr_idx;
    logic                w_haddr_ok;
    logic                w_idx_ok;
    logic                w_timeout;

    assign w_accept    = ((r_state == StIdle) || (r_state == StDone)) && bus.valid;
    assign w_haddr_idx = bus.haddr[SLV_LSB +: SlvW];
    assign w_haddr_ok  = 32'(w_haddr_idx) < NUM_SLV;
    assign w_idx_ok    = 32'(r_idx) < NUM_SLV;
    assign w_idx_d     = w_accept ? w_haddr_idx : r_idx;
    // Counter holds the number of ACCESS cycles already spent waiting for pready.
    assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CntW'(CntLastI));

    // Next state and timeout counter
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle, StDone: begin
                if (!bus.valid) begin
                    w_state_d = StIdle;
                end else if (bus.hwrite) begin
                    w_state_d = StWdata;
                end else begin
                    w_state_d = w_haddr_ok ? StSetup : StErr1;
                end
            end
            StWdata: w_state_d = w_idx_ok ? StSetup : StErr1;
            StSetup: begin
                w_state_d = StAccess;
                w_cnt_d   = '0;
            end
            StAccess: begin
                if (bus.pready) begin
                    w_state_d = bus.pslverr ? StErr1 : StDone;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                    if (w_timeout) begin
                        w_state_d = StErr1;
                    end
                end
            end
            StErr1:  w_state_d = StErr2;
            StErr2:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Output values for the upcoming state, so every bus output comes straight from a flop
    always_comb begin
        w_hreadyout_d = (w_state_d == StIdle) || (w_state_d == StDone) || (w_state_d == StErr2);
        w_hresp_d     = ((w_state_d == StErr1) || (w_state_d == StErr2)) ? 2'b01 : 2'b00;
        w_penable_d   = (w_state_d == StAccess);
        w_psel_d      = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            w_psel_d[i] = ((w_state_d == StSetup) || (w_state_d == StAccess)) &&
                          (32'(w_idx_d) == i);
        end
    end

    // State and control output registers
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 2'b00;
            r_psel      <= '0;
            r_penable   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_idx       <= w_idx_d;
            r_hreadyout <= w_hreadyout_d;
            r_hresp     <= w_hresp_d;
            r_psel      <= w_psel_d;
            r_penable   <= w_penable_d;
        end
    end

    // Address/data path: latch on accept, write data in WDATA, read data on a good read
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_hrdata <= '0;
        end else begin
            if (w_accept) begin
                r_paddr  <= bus.haddr;
                r_pwrite <= bus.hwrite;
            end
            if (r_state == StWdata) begin
                r_pwdata <= bus.hwdata;
            end
            if ((r_state == StAccess) && bus.pready && !bus.pslverr && !r_pwrite) begin
                r_hrdata <= bus.prdata;
            end
        end
    end

    assign bus.hrdata    = r_hrdata;
    assign bus.hreadyout = r_hreadyout;
    assign bus.hresp     = r_hresp;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.pwrite    = r_pwrite;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
endmodule

// File: tb/tb_ahb_apb_bridge_ctrl_p.sv
// Bench for ahb_apb_bridge_ctrl_p: transaction-level model expands each transfer into its
// expected per-cycle bus outputs; a compare process checks them every cycle.
module tb_ahb_apb_bridge_ctrl_p;
    // Five slaves so the 3-bit index field can hold out-of-range values (e.g. idx=5).
    localparam int unsigned NumSlv  = 5;
    localparam int unsigned SlvLsb  = 12;
    localparam int unsigned SlvW    = 3;
    localparam int unsigned Timeout = 16;

    logic hclk    = 1'b0;
    logic hresetn = 1'b0;
    always #5 hclk = ~hclk;

    ahb_apb_bridge_ctrl_p_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(NumSlv)) bus_if ();

    ahb_apb_bridge_ctrl_p #(
        .ADDR_W (32),
        .DATA_W (32),
        .NUM_SLV(NumSlv),
        .SLV_LSB(SlvLsb),
        .TIMEOUT(Timeout)
    ) dut (
        .i_hclk   (hclk),
        .i_hresetn(hresetn),
        .bus      (bus_if)
    );

    typedef enum int {PhIdle, PhWdata, PhSetup, PhAccess, PhDone, PhErr1, PhErr2} ph_e;

    typedef struct packed {
        logic              hreadyout;
        logic [1:0]        hresp;
        logic [NumSlv-1:0] psel;
        logic              penable;
        logic [31:0]       paddr;
        logic [31:0]       pwdata;
        logic              pwrite;
        logic [31:0]       hrdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t ce;
    int   total = 0;
    int   bad   = 0;

    // Model state: what the bridge has latched so far
    logic [31:0] m_paddr, m_pwdata, m_hrdata;
    logic        m_pwrite;
    int unsigned m_idx;

    // Per-transfer observations used by the literal checks
    int                obs_n, obs_pen, obs_lat;
    logic [NumSlv-1:0] obs_first_psel, obs_any_psel, obs_e1_psel;
    logic [31:0]       obs_setup_pwdata;
    logic              obs_setup_pwrite;
    logic [2:0]        obs_e1, obs_e2;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
        end
    endfunction

    function automatic exp_t model_out(input ph_e ph);
        exp_t e;
        e.hreadyout = (ph == PhIdle) || (ph == PhDone) || (ph == PhErr2);
        e.hresp     = ((ph == PhErr1) || (ph == PhErr2)) ? 2'b01 : 2'b00;
        e.penable   = (ph == PhAccess);
        e.psel      = ((ph == PhSetup) || (ph == PhAccess)) ? (NumSlv'(1) << m_idx) : '0;
        e.paddr     = m_paddr;
        e.pwdata    = m_pwdata;
        e.pwrite    = m_pwrite;
        e.hrdata    = m_hrdata;
        return e;
    endfunction

    // Every cycle with a pending expectation is checked field by field.
    always @(negedge hclk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("cyc_hreadyout", 64'(bus_if.hreadyout), 64'(ce.hreadyout));
            chk("cyc_hresp",     64'(bus_if.hresp),     64'(ce.hresp));
            chk("cyc_psel",      64'(bus_if.psel),      64'(ce.psel));
            chk("cyc_penable",   64'(bus_if.penable),   64'(ce.penable));
            chk("cyc_paddr",     64'(bus_if.paddr),     64'(ce.paddr));
            chk("cyc_pwdata",    64'(bus_if.pwdata),    64'(ce.pwdata));
            chk("cyc_pwrite",    64'(bus_if.pwrite),    64'(ce.pwrite));
            chk("cyc_hrdata",    64'(bus_if.hrdata),    64'(ce.hrdata));
        end
    end

    task automatic advance(input ph_e ph);
        exp_t e;
        e = model_out(ph);
        @(posedge hclk);
        exp_q.push_back(e);
        #1;
        obs_n++;
        if (obs_n == 1) obs_first_psel = bus_if.psel;
        obs_any_psel = obs_any_psel | bus_if.psel;
        if (bus_if.penable) obs_pen++;
        if (bus_if.hreadyout && (obs_lat == 0)) obs_lat = obs_n;
        if (ph == PhSetup) begin
            obs_setup_pwdata = bus_if.pwdata;
            obs_setup_pwrite = bus_if.pwrite;
        end
        if (ph == PhErr1) begin
            obs_e1      = {bus_if.hreadyout, bus_if.hresp};
            obs_e1_psel = bus_if.psel;
        end
        if (ph == PhErr2) obs_e2 = {bus_if.hreadyout, bus_if.hresp};
    endtask

    task automatic junk();
        bus_if.hwdata  = $urandom;
        bus_if.prdata  = $urandom;
        bus_if.pready  = 1'($urandom);
        bus_if.pslverr = 1'($urandom);
    endtask

    // Called in a cycle where the bridge can accept (IDLE or DONE).
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input int waits, input bit serr, input logic [31:0] rd,
                       input bit idle_after);
        ph_e         ph[$];
        int unsigned idx;
        int          nacc;
        int          a;
        obs_n = 0; obs_pen = 0; obs_lat = 0;
        obs_first_psel = '0; obs_any_psel = '0; obs_e1_psel = '1;
        obs_e1 = '0; obs_e2 = '0; obs_setup_pwdata = '0; obs_setup_pwrite = 1'b0;

        idx = (addr >> SlvLsb) & ((1 << SlvW) - 1);
        if (wr) ph.push_back(PhWdata);
        if (idx >= NumSlv) begin
            ph.push_back(PhErr1);
            ph.push_back(PhErr2);
        end else begin
            ph.push_back(PhSetup);
            nacc = (waits >= int'(Timeout)) ? int'(Timeout) : waits + 1;
            repeat (nacc) ph.push_back(PhAccess);
            if ((waits >= int'(Timeout)) || serr) begin
                ph.push_back(PhErr1);
                ph.push_back(PhErr2);
            end else begin
                ph.push_back(PhDone);
            end
        end

        junk();
        bus_if.valid  = 1'b1;
        bus_if.hwrite = wr;
        bus_if.haddr  = addr;
        m_paddr  = addr;
        m_pwrite = wr;
        m_idx    = idx;

        a = 0;
        for (int j = 0; j < ph.size(); j++) begin
            advance(ph[j]);
            junk();
            if (ph[j] == PhDone) begin
                bus_if.valid = 1'b0;
            end else begin
                bus_if.valid  = 1'($urandom);
                bus_if.hwrite = 1'($urandom);
                bus_if.haddr  = $urandom;
            end
            if (ph[j] == PhWdata) begin
                bus_if.hwdata = wd;
                m_pwdata      = wd;
            end
            if (ph[j] == PhAccess) begin
                bus_if.pready = (a == waits);
                if (a == waits) begin
                    bus_if.pslverr = serr;
                    bus_if.prdata  = rd;
                    if (!serr && !wr) m_hrdata = rd;
                end
                a++;
            end
        end
        if ((ph[ph.size()-1] == PhErr2) || idle_after) begin
            advance(PhIdle);
            bus_if.valid = 1'b0;
        end
    endtask

    initial begin
        bus_if.valid   = 1'b0;
        bus_if.hwrite  = 1'b0;
        bus_if.haddr   = '0;
        bus_if.hwdata  = '0;
        bus_if.prdata  = '0;
        bus_if.pready  = 1'b0;
        bus_if.pslverr = 1'b0;
        m_paddr = '0; m_pwdata = '0; m_hrdata = '0; m_pwrite = 1'b0; m_idx = 0;

        repeat (2) @(posedge hclk);
        #1;
        chk("rst_hreadyout", 64'(bus_if.hreadyout), 64'd1);
        chk("rst_hresp",     64'(bus_if.hresp),     64'd0);
        chk("rst_psel",      64'(bus_if.psel),      64'd0);
        chk("rst_penable",   64'(bus_if.penable),   64'd0);
        chk("rst_paddr",     64'(bus_if.paddr),     64'd0);
        chk("rst_pwdata",    64'(bus_if.pwdata),    64'd0);
        chk("rst_pwrite",    64'(bus_if.pwrite),    64'd0);
        chk("rst_hrdata",    64'(bus_if.hrdata),    64'd0);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // Read slave 2, no wait, left in DONE
        txn(1'b0, 32'h0000_2010, 32'h0, 0, 1'b0, 32'hCAFE_0001, 1'b0);
        chk("rd2_psel_t1",  64'(obs_first_psel),   64'h04);
        chk("rd2_latency",  64'(obs_lat),          64'd3);
        chk("rd2_pen_cyc",  64'(obs_pen),          64'd1);
        chk("rd2_hrdata",   64'(bus_if.hrdata),    64'hCAFE_0001);
        chk("rd2_hready",   64'(bus_if.hreadyout), 64'd1);
        chk("rd2_hresp",    64'(bus_if.hresp),     64'd0);

        // Back-to-back read accepted in DONE: SETUP follows at once
        txn(1'b0, 32'h0000_3000, 32'h0, 0, 1'b0, 32'h0BAD_F00D, 1'b1);
        chk("b2b_psel_t1",  64'(obs_first_psel), 64'h08);
        chk("b2b_latency",  64'(obs_lat),        64'd3);

        // Write slave 0
        txn(1'b1, 32'h0000_0004, 32'h1234_5678, 0, 1'b0, 32'h0, 1'b1);
        chk("wr_latency",   64'(obs_lat),          64'd4);
        chk("wr_pwdata",    64'(obs_setup_pwdata), 64'h1234_5678);
        chk("wr_pwrite",    64'(obs_setup_pwrite), 64'd1);

        // Read with three wait states
        txn(1'b0, 32'h0000_1040, 32'h0, 3, 1'b0, 32'h5555_AAAA, 1'b1);
        chk("wait_pen_cyc", 64'(obs_pen), 64'd4);
        chk("wait_latency", 64'(obs_lat), 64'd6);

        // Slave error
        txn(1'b0, 32'h0000_0008, 32'h0, 0, 1'b1, 32'hDEAD_DEAD, 1'b1);
        chk("serr_err1",    64'(obs_e1),  64'b001);
        chk("serr_err2",    64'(obs_e2),  64'b101);
        chk("serr_latency", 64'(obs_lat), 64'd4);

        // Timeout with pready stuck low
        txn(1'b0, 32'h0000_4000, 32'h0, 40, 1'b0, 32'h0, 1'b1);
        chk("tmo_pen_cyc",   64'(obs_pen),     64'd16);
        chk("tmo_err1_psel", 64'(obs_e1_psel), 64'd0);
        chk("tmo_err1",      64'(obs_e1),      64'b001);

        // Decode error, idx=5
        txn(1'b0, 32'h0000_5000, 32'h0, 0, 1'b0, 32'h0, 1'b1);
        chk("dec_any_psel", 64'(obs_any_psel), 64'd0);
        chk("dec_latency",  64'(obs_lat),      64'd2);
        chk("dec_err1",     64'(obs_e1),       64'b001);

        // Reset in the middle of ACCESS
        bus_if.valid  = 1'b1;
        bus_if.hwrite = 1'b0;
        bus_if.haddr  = 32'h0000_1000;
        bus_if.pready = 1'b0;
        @(posedge hclk);
        #1;
        bus_if.valid = 1'b0;
        @(posedge hclk);
        #1;
        chk("mrst_pre_pen",  64'(bus_if.penable), 64'd1);
        chk("mrst_pre_psel", 64'(bus_if.psel),    64'h02);
        #2;
        hresetn = 1'b0;
        #1;
        chk("mrst_psel",    64'(bus_if.psel),      64'd0);
        chk("mrst_penable", 64'(bus_if.penable),   64'd0);
        chk("mrst_hready",  64'(bus_if.hreadyout), 64'd1);
        chk("mrst_hrdata",  64'(bus_if.hrdata),    64'd0);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        m_paddr = '0; m_pwdata = '0; m_hrdata = '0; m_pwrite = 1'b0; m_idx = 0;
        @(posedge hclk);
        #1;

        // Randomized transfers
        for (int n = 0; n < 300; n++) begin
            int r;
            int w;
            r = int'($urandom_range(0, 15));
            if (r < 10)      w = r % 4;
            else if (r < 14) w = int'($urandom_range(4, 15));
            else             w = int'($urandom_range(16, 20));
            txn(1'($urandom), $urandom, $urandom, w, ($urandom_range(0, 7) == 0), $urandom,
                1'($urandom));
        end

        @(negedge hclk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
